// File: rtl/sqrt_sched.sv
// sqrt_sched: round-robin front end that shares one multi-cycle sqrt core
// among NREQ requesters. Only one request is in flight at a time. A request
// whose core never answers is completed with an error response.
module sqrt_sched #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*8-1:0] req_rad,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   resp_valid,
  output logic [7:0]        resp_root,
  output logic [7:0]        resp_rem,
  output logic              resp_err,
  output logic              start,
  output logic [7:0]        rad,
  input  logic              busy,
  input  logic              valid,
  input  logic [7:0]        root,
  input  logic [7:0]        rem,
  output logic              sched_busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

  state_t          state;
  logic [IW-1:0]   last_grant;
  logic [IW-1:0]   tag;
  logic [IW-1:0]   gnt;
  logic            found;
  logic            take;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_nxt;
  logic [NREQ-1:0] gnt_oh;
  logic [NREQ-1:0] tag_oh;

  // Round-robin search: first pending requester after the last one served.
  always_comb begin
    int idx;
    found = 1'b0;
    gnt   = last_grant;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(last_grant) + 1 + k) % NREQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        gnt   = IW'(idx);
      end
    end
  end

  // Accept is combinational so the requester sees it in the grant cycle;
  // it is masked during reset so nothing transfers while rst is held.
  assign take       = (state == IDLE) && !busy && found && !rst;
  assign gnt_oh     = NREQ'(1) << gnt;
  assign tag_oh     = NREQ'(1) << tag;
  assign req_ready  = take ? gnt_oh : '0;
  assign cnt_nxt    = cnt + 1'b1;
  assign sched_busy = (state != IDLE);

  // Scheduler FSM; start/resp_* are registered and set on the transition
  // into LAUNCH/RESP so they are high for exactly that state's cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= IW'(NREQ - 1);
      tag        <= '0;
      rad        <= '0;
      cnt        <= '0;
      start      <= 1'b0;
      resp_valid <= '0;
      resp_root  <= '0;
      resp_rem   <= '0;
      resp_err   <= 1'b0;
    end else begin
      start      <= 1'b0;
      resp_valid <= '0;
      case (state)
        IDLE: begin
          if (take) begin
            last_grant <= gnt;
            tag        <= gnt;
            rad        <= req_rad[8*gnt +: 8];
            start      <= 1'b1;
            state      <= LAUNCH;
          end
        end
        LAUNCH: begin
          // any valid seen here belongs to an earlier operation: ignore it
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (valid) begin
            resp_root  <= root;
            resp_rem   <= rem;
            resp_err   <= 1'b0;
            resp_valid <= tag_oh;
            state      <= RESP;
          end else if (cnt_nxt == CW'(TIMEOUT)) begin
            resp_root  <= '0;
            resp_rem   <= '0;
            resp_err   <= 1'b1;
            resp_valid <= tag_oh;
            state      <= RESP;
          end else begin
            cnt <= cnt_nxt;
          end
        end
        RESP: begin
          resp_root <= '0;
          resp_rem  <= '0;
          resp_err  <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/sqrt_sched.md
SQRT_SCHED -- requirements
Module: sqrt_sched

Interface
REQ-001 Parameter NREQ, 4, number of requesters sharing one sqrt core (2..8).
REQ-002 Parameter TIMEOUT, 64, max cycles waited for core valid after start (1..255).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 req_valid  input  NREQ  per-requester request pending.
REQ-006 req_rad  input  NREQ*8  radicands; requester i uses bits [8i+7:8i].
REQ-007 req_ready  output  NREQ  one-hot accept pulse; transfer when req_valid[i] & req_ready[i].
REQ-008 resp_valid  output  NREQ  one-hot result pulse to the owning requester.
REQ-009 resp_root  output  8  result root; valid only with resp_valid.
REQ-010 resp_rem  output  8  result remainder; valid only with resp_valid.
REQ-011 resp_err  output  1  timeout flag; valid only with resp_valid.
REQ-012 start  output  1  one-cycle start pulse to sqrt core.
REQ-013 rad  output  8  radicand to core; held stable from start until core valid or timeout.
REQ-014 busy  input  1  core calculation in progress.
REQ-015 valid  input  1  core result valid.
REQ-016 root  input  8  core root.
REQ-017 rem  input  8  core remainder.
REQ-018 sched_busy  output  1  high whenever state != IDLE.

Function
REQ-019 FSM states IDLE, LAUNCH, WAIT, RESP; exactly one per cycle.
REQ-020 IDLE: if any req_valid and busy==0, grant g, pulse req_ready[g] this cycle, latch req_rad[g] and tag g, go LAUNCH; else stay.
REQ-021 IDLE with busy==1: no grant, no req_ready, stay IDLE.
REQ-022 Round-robin: search starts at last_grant+1 modulo NREQ; first asserted req_valid wins.
REQ-023 last_grant updates only on grant; unselected requests stay pending, never dropped.
REQ-024 Requester may deassert req_valid before grant; no transfer, no side effect.
REQ-025 LAUNCH: start=1 for exactly this cycle, rad=latched value; go WAIT; clear timeout counter.
REQ-026 valid asserted during LAUNCH is ignored (stale).
REQ-027 WAIT: on valid==1 capture root/rem, err=0, go RESP.
REQ-028 WAIT: counter increments each cycle without valid; at count==TIMEOUT capture root=0, rem=0, err=1, go RESP.
REQ-029 valid and timeout in same cycle: valid wins, err=0.
REQ-030 RESP: resp_valid[tag]=1 one cycle with captured root/rem/err; go IDLE.
REQ-031 Latency: grant cycle t, start t+1, core valid t+1+k (k>=1), resp_valid t+2+k.
REQ-032 At most one request in flight; no new grant in RESP or in the RESP->IDLE cycle's predecessor.
REQ-033 req_ready, resp_valid, start are zero outside their defined states.
REQ-034 Timeout counter width ceil(log2(TIMEOUT+1)); no wrap before TIMEOUT.

Reset
REQ-035 rst high asynchronously forces IDLE; all outputs 0; last_grant=NREQ-1 (requester 0 first priority).
REQ-036 rst mid-operation aborts in-flight request; no resp_valid issued for it; requester must re-request.
REQ-037 First grant allowed on first rising edge after rst deasserts.

Verification
REQ-038 Single request: req_valid[1], rad=200, core k=4 -> req_ready[1] at t, start t+1, resp_valid[1] t+6, root=14, rem=4, err=0.
REQ-039 All four request simultaneously after reset (rads 0,144,255,17) -> grants order 0,1,2,3; results (0,0),(12,0),(15,30),(4,1) each to own requester.
REQ-040 Fairness: req 0 and 2 held continuously for 6 transactions -> grants alternate 0,2,0,2,0,2.
REQ-041 Core never asserts valid, TIMEOUT=64 -> resp_valid at start+65 with err=1, root=0, rem=0; scheduler returns IDLE, next request served.
REQ-042 rst asserted in WAIT -> outputs 0 same cycle, no resp_valid; after release req 3 rad=81 -> root=9, rem=0.
REQ-043 busy held high 10 cycles with req_valid[0] -> no req_ready until busy falls; grant the cycle busy==0.
